// File: rtl/transform_sched_ctrl.sv
// Sequencer for the transform+activation datapath: optional weight load, row issue,
// in-flight result tracking with output backpressure, and a done pulse once drained.
module transform_sched_ctrl #(
  parameter int psys       = 32,
  parameter int featureLen = 128,
  parameter int k          = 1024,
  parameter int PIPE_LAT   = 2 * psys + 2,
  localparam int W_WORDS   = featureLen * featureLen / psys,
  localparam int WAW       = $clog2(W_WORDS),
  localparam int RAW       = $clog2(k),
  localparam int CW        = $clog2(PIPE_LAT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [RAW:0]   numRows,
  input  logic           modeCfg,
  input  logic           skipWeightLoad,
  input  logic           wValid,
  output logic           wReady,
  output logic           weightWriteEnable,
  output logic [WAW-1:0] weightAddr,
  output logic [RAW-1:0] rowbuffer_address,
  output logic           rowRead,
  output logic           sysEnable,
  output logic           mode,
  output logic           resultValid,
  output logic [RAW-1:0] resultRowIdx,
  input  logic           resultReady,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [RAW:0]   r_num_rows;
  logic [RAW:0]   r_row_cnt;
  logic [WAW-1:0] r_waddr;
  logic           r_mode;
  logic [CW-1:0]  r_inflight;
  logic [PIPE_LAT-1:0] r_pipe_vld;
  logic [RAW-1:0] r_pipe_idx [PIPE_LAT];

  logic           w_stall;
  logic           w_issue;
  logic           w_wr;
  logic           w_retire;
  logic           w_start_ok;
  logic           w_last_word;
  logic           w_last_row;
  logic [RAW:0]   w_num_clamped;
  logic [CW-1:0]  w_inflight_next;

  // A stalled result freezes the entire pipeline, including row issue.
  assign w_stall         = r_pipe_vld[PIPE_LAT-1] & ~resultReady;
  assign w_issue         = (r_state == S_COMPUTE) & ~w_stall;
  assign w_wr            = (r_state == S_LOAD_W) & wValid;
  assign w_retire        = r_pipe_vld[PIPE_LAT-1] & ~w_stall;
  assign w_start_ok      = (r_state == S_IDLE) & start;
  assign w_last_word     = (r_waddr == WAW'(W_WORDS - 1));
  assign w_last_row      = (r_row_cnt == (r_num_rows - (RAW+1)'(1)));
  assign w_num_clamped   = (numRows > (RAW+1)'(k)) ? (RAW+1)'(k) : numRows;
  assign w_inflight_next = r_inflight + CW'(w_issue) - CW'(w_retire);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; DRAIN looks ahead so FIN lands the cycle after the last retire.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!skipWeightLoad) begin
            w_state_next = S_LOAD_W;
          end else if (w_num_clamped == (RAW+1)'(0)) begin
            w_state_next = S_FIN;
          end else begin
            w_state_next = S_COMPUTE;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (w_wr && w_last_word) begin
          w_state_next = (r_num_rows == (RAW+1)'(0)) ? S_FIN : S_COMPUTE;
        end else begin
          w_state_next = S_LOAD_W;
        end
      end
      S_COMPUTE: begin
        if (w_issue && w_last_row) begin
          w_state_next = S_DRAIN;
        end else begin
          w_state_next = S_COMPUTE;
        end
      end
      S_DRAIN: begin
        if (w_inflight_next == CW'(0)) begin
          w_state_next = S_FIN;
        end else begin
          w_state_next = S_DRAIN;
        end
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Job configuration, row counter and weight address counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num_rows <= (RAW+1)'(0);
      r_row_cnt  <= (RAW+1)'(0);
      r_waddr    <= WAW'(0);
      r_mode     <= 1'b0;
    end else if (w_start_ok) begin
      r_num_rows <= w_num_clamped;
      r_row_cnt  <= (RAW+1)'(0);
      r_waddr    <= WAW'(0);
      r_mode     <= modeCfg;
    end else if (r_state == S_FIN) begin
      r_row_cnt  <= (RAW+1)'(0);
      r_waddr    <= WAW'(0);
      r_mode     <= 1'b0;
    end else if (w_wr) begin
      r_waddr    <= w_last_word ? WAW'(0) : r_waddr + WAW'(1);
    end else if (w_issue) begin
      r_row_cnt  <= r_row_cnt + (RAW+1)'(1);
      r_waddr    <= w_last_word ? WAW'(0) : r_waddr + WAW'(1);
    end else begin
      r_row_cnt  <= r_row_cnt;
    end
  end

  // Result tracking shift register; models datapath latency and holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe_vld <= '0;
      r_inflight <= CW'(0);
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_pipe_idx[i] <= RAW'(0);
      end
    end else if (!w_stall) begin
      r_pipe_vld    <= {r_pipe_vld[PIPE_LAT-2:0], w_issue};
      r_inflight    <= w_inflight_next;
      r_pipe_idx[0] <= w_issue ? r_row_cnt[RAW-1:0] : RAW'(0);
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end else begin
      r_inflight <= r_inflight;
    end
  end

  assign wReady            = (r_state == S_LOAD_W);
  assign weightWriteEnable = w_wr;
  assign weightAddr        = r_waddr;
  assign rowbuffer_address = (r_state == S_COMPUTE) ? r_row_cnt[RAW-1:0] : RAW'(0);
  assign rowRead           = w_issue;
  assign sysEnable         = w_issue;
  assign mode              = r_mode;
  assign resultValid       = r_pipe_vld[PIPE_LAT-1];
  assign resultRowIdx      = r_pipe_idx[PIPE_LAT-1];
  assign busy              = (r_state != S_IDLE);
  assign done              = (r_state == S_FIN);

endmodule

// File: tb/tb_transform_sched_ctrl.sv
// Randomised bench for transform_sched_ctrl against a queue-based reference model of
// weight loading, row issue, result latency under backpressure and job completion.
module tb_transform_sched_ctrl;

  localparam int K        = 1024;
  localparam int W_WORDS  = 512;
  localparam int PIPE_LAT = 66;

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] numRows;
  logic        modeCfg;
  logic        skipWeightLoad;
  logic        wValid;
  logic        wReady;
  logic        weightWriteEnable;
  logic [8:0]  weightAddr;
  logic [9:0]  rowbuffer_address;
  logic        rowRead;
  logic        sysEnable;
  logic        mode;
  logic        resultValid;
  logic [9:0]  resultRowIdx;
  logic        resultReady;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  transform_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .numRows(numRows), .modeCfg(modeCfg),
    .skipWeightLoad(skipWeightLoad), .wValid(wValid), .wReady(wReady),
    .weightWriteEnable(weightWriteEnable), .weightAddr(weightAddr),
    .rowbuffer_address(rowbuffer_address), .rowRead(rowRead), .sysEnable(sysEnable),
    .mode(mode), .resultValid(resultValid), .resultRowIdx(resultRowIdx),
    .resultReady(resultReady), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, 32'({wReady, weightWriteEnable, rowRead, sysEnable, mode,
                                 resultValid, busy, done}), 32'd0);
    check_eq({tag, "_addr"}, 32'({weightAddr, rowbuffer_address, resultRowIdx}), 32'd0);
  endtask

  // One job: cycle 0 carries start; the model predicts every later cycle until done.
  task automatic run_job(input int n, input bit skip, input bit mcfg, input int wpat,
                         input int bp_len, input bit rnd_rdy, input bit inj, input int abort_row);
    int  n_eff, loads_left, rows_next, ucnt, done_cyc, done_cnt, load_len, stalls, bp_left, pops;
    int  cyc;
    bit  exp_load, exp_wr, exp_issue, exp_valid, exp_stall, exp_done, finished, wv, rdy;
    int  q_row[$];
    int  q_u[$];
    n_eff      = (n > K) ? K : n;
    loads_left = skip ? 0 : W_WORDS;
    rows_next  = 0;
    ucnt       = 0;
    done_cyc   = -1;
    done_cnt   = 0;
    load_len   = 0;
    stalls     = 0;
    bp_left    = bp_len;
    pops       = 0;
    finished   = 1'b0;

    @(posedge clk); #1;
    start          = 1'b1;
    numRows        = 11'(n);
    modeCfg        = mcfg;
    skipWeightLoad = skip;
    wValid         = 1'($urandom_range(0, 1));
    resultReady    = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_wready", 32'(wReady), 32'd0);
    check_eq("idle_rvalid", 32'(resultValid), 32'd0);

    for (cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      @(posedge clk); #1;
      exp_load  = (loads_left > 0);
      exp_valid = (q_row.size() > 0) && ((ucnt - q_u[0]) == PIPE_LAT);
      exp_done  = !exp_load && (rows_next == n_eff) && (q_row.size() == 0);
      case (wpat)
        0:       wv = 1'b1;
        1:       wv = ((cyc - 1) % 2 == 0);
        default: wv = 1'($urandom_range(0, 1));
      endcase
      rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (exp_valid && bp_left > 0) begin
        rdy = 1'b0;
        bp_left--;
      end
      start          = inj && (cyc == 5);
      numRows        = 11'd3;
      skipWeightLoad = 1'($urandom_range(0, 1));
      modeCfg        = 1'($urandom_range(0, 1));
      wValid         = wv;
      resultReady    = rdy;
      exp_wr    = exp_load && wv;
      exp_stall = exp_valid && !rdy;
      exp_issue = !exp_load && (rows_next < n_eff) && !exp_stall;

      if (abort_row >= 0 && exp_issue && rows_next == abort_row) begin
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end

      @(negedge clk);
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("done", 32'(done), 32'(exp_done));
      check_eq("mode", 32'(mode), 32'(mcfg));
      check_eq("wready", 32'(wReady), 32'(exp_load));
      check_eq("wr_en", 32'(weightWriteEnable), 32'(exp_wr));
      check_eq("row_read", 32'(rowRead), 32'(exp_issue));
      check_eq("sys_en", 32'(sysEnable), 32'(exp_issue));
      check_eq("rvalid", 32'(resultValid), 32'(exp_valid));
      if (exp_wr) check_eq("w_addr_load", 32'(weightAddr), 32'(W_WORDS - loads_left));
      if (exp_issue) begin
        check_eq("row_addr", 32'(rowbuffer_address), 32'(rows_next % K));
        check_eq("w_addr_comp", 32'(weightAddr), 32'(rows_next % W_WORDS));
      end
      if (exp_valid) check_eq("result_idx", 32'(resultRowIdx), 32'(q_row[0]));
      if (wReady) load_len++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end

      if (exp_wr) loads_left--;
      if (exp_issue) begin
        q_row.push_back(rows_next);
        q_u.push_back(ucnt);
        rows_next++;
      end
      if (exp_valid && rdy) begin
        void'(q_row.pop_front());
        void'(q_u.pop_front());
        pops++;
      end
      if (exp_stall) stalls++;
      else ucnt++;
      if (exp_done) finished = 1'b1;
    end

    check_eq("timeout", 32'(finished), 32'd1);
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("results", 32'(pops), 32'(n_eff));
    if (!skip && wpat < 2) check_eq("load_len", 32'(load_len), (wpat == 0) ? 32'd512 : 32'd1023);
    if (bp_len > 0) check_eq("stall_cycles", 32'(stalls), 32'(bp_len));
    if (wpat == 0 && !rnd_rdy)
      check_eq("done_cycle", 32'(done_cyc),
               32'((skip ? 0 : W_WORDS) + ((n_eff == 0) ? 1 : n_eff + PIPE_LAT + 1) + bp_len));

    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_done", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; numRows = 11'd0; modeCfg = 1'b0; skipWeightLoad = 1'b0;
    wValid = 1'b0; resultReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    run_job(100, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 40);  // reset mid-compute
    run_job(4, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, -1);    // load then compute
    run_job(1024, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, -1); // full depth, ignored start
    run_job(8, 1'b1, 1'b0, 0, 10, 1'b0, 1'b0, -1);   // 10-cycle backpressure
    run_job(0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, -1);    // empty job
    run_job(5, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, -1);    // wValid gaps
    run_job(0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, -1);    // load only
    run_job(1500, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, -1); // clamped to depth
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(0, 300), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2, 0, 1'b1, 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
